// File: rtl/noc_rr_arbiter_pkg.sv
// Shared definitions for the NoC output-port arbiter: state decode names,
// router port indices and default parameter values.
package noc_arb_pkg;

   // State is decoded from the owner/rts registers; it is never stored.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      XFER = 2'd2,
      GAP  = 2'd3
   } arb_state_e;

   localparam int LOCAL = 0;
   localparam int NORTH = 1;
   localparam int EAST  = 2;
   localparam int WEST  = 3;
   localparam int SOUTH = 4;

   localparam int DEFAULT_NUM_PORTS = 5;
   localparam int DEFAULT_MAX_BURST = 8;

endpackage

// File: rtl/noc_rr_arbiter_if.sv
// Arbiter handshake bundle: requests and downstream DCTS in, flit strobes,
// crossbar select and RTS out. The slave modport is the arbiter side.
interface noc_rr_arbiter_if
   import noc_arb_pkg::*;
#(
   parameter int NUM_PORTS = DEFAULT_NUM_PORTS
);
   logic [NUM_PORTS-1:0] req;
   logic                 dcts;
   logic [NUM_PORTS-1:0] grant;
   logic [NUM_PORTS-1:0] xbar_sel;
   logic                 rts;

   modport master (
      output req,
      output dcts,
      input  grant,
      input  xbar_sel,
      input  rts
   );

   modport slave (
      input  req,
      input  dcts,
      output grant,
      output xbar_sel,
      output rts
   );
endinterface

// File: rtl/noc_rr_arbiter_rr_pick.sv
// Rotating priority search: returns the first requesting port found when
// scanning upward from start_i, wrapping modulo NUM_PORTS. Outputs are zero
// when vld_i is low.
module rr_pick #(
   parameter int NUM_PORTS = 5
) (
   input  logic [NUM_PORTS-1:0]         req_i,
   input  logic [$clog2(NUM_PORTS)-1:0] start_i,
   input  logic                         vld_i,
   output logic [NUM_PORTS-1:0]         win_o,
   output logic                         any_o
);

   // Scan from the start index; the first hit wins, so the result is one-hot.
   always_comb begin
      int  idx;
      logic found;
      win_o = '0;
      found = 1'b0;
      idx   = 0;
      if (vld_i) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(start_i) + i) % NUM_PORTS;
            if (req_i[idx] && !found) begin
               win_o[idx] = 1'b1;
               found      = 1'b1;
            end
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/noc_rr_arbiter.sv
// Sticky round-robin output-port arbiter with RTS/DCTS flit handshake.
// Define ARB_BURST_LIMIT_EN to cap consecutive transfers to one owner at
// MAX_BURST before the owner drops to lowest priority.
//
// state | meaning
// IDLE  | no owner, rts low
// WAIT  | owner held, rts high, downstream not ready
// XFER  | rts and dcts high, one flit moves this cycle
// GAP   | owner held, rts low for one cycle after a transfer
module noc_rr_arbiter
   import noc_arb_pkg::*;
#(
   parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
   parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
   input logic             clk,
   input logic             rst,
   noc_rr_arbiter_if.slave arb_if
);

   localparam int IDX_W = $clog2(NUM_PORTS);

   logic [NUM_PORTS-1:0] owner_q, owner_d;
   logic                 rts_q, rts_d;
   arb_state_e           state;
   logic [IDX_W-1:0]     owner_idx;
   logic [IDX_W-1:0]     next_idx;
   logic [IDX_W-1:0]     start_idx;
   logic                 pick_vld;
   logic [NUM_PORTS-1:0] pick_win;
   logic                 pick_any;
   logic                 at_limit;

`ifdef ARB_BURST_LIMIT_EN
   localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   assign at_limit = (cnt_q == CNT_W'(MAX_BURST - 1));
`else
   assign at_limit = 1'b0;
`endif

   // Decode the handshake phase from the owner/rts registers and dcts.
   always_comb begin
      if (owner_q == '0)   state = IDLE;
      else if (!rts_q)     state = GAP;
      else if (arb_if.dcts) state = XFER;
      else                 state = WAIT;
   end

   // Convert the one-hot owner to an index and its wrapped successor.
   always_comb begin
      owner_idx = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (owner_q[i]) owner_idx = IDX_W'(i);
      end
      next_idx = (owner_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : owner_idx + IDX_W'(1);
   end

   // From IDLE the search is fixed priority from Local; after a transfer it
   // starts at the owner (sticky) unless the burst cap pushes it past.
   assign pick_vld  = (state == IDLE) || (state == XFER);
   assign start_idx = (state == XFER) ? (at_limit ? next_idx : owner_idx) : IDX_W'(LOCAL);

   rr_pick #(
      .NUM_PORTS(NUM_PORTS)
   ) u_pick (
      .req_i  (arb_if.req),
      .start_i(start_idx),
      .vld_i  (pick_vld),
      .win_o  (pick_win),
      .any_o  (pick_any)
   );

   // State register: owner, rts and (optionally) burst count.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= '0;
         rts_q   <= 1'b0;
`ifdef ARB_BURST_LIMIT_EN
         cnt_q   <= '0;
`endif
      end else begin
         owner_q <= owner_d;
         rts_q   <= rts_d;
`ifdef ARB_BURST_LIMIT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Next-state logic; WAIT holds everything because rts is never retracted.
   always_comb begin
      owner_d = owner_q;
      rts_d   = rts_q;
`ifdef ARB_BURST_LIMIT_EN
      cnt_d   = cnt_q;
`endif
      case (state)
         IDLE: begin
            if (pick_any) begin
               owner_d = pick_win;
               rts_d   = 1'b1;
            end
`ifdef ARB_BURST_LIMIT_EN
            cnt_d = '0;
`endif
         end
         WAIT: begin
            owner_d = owner_q;
         end
         XFER: begin
            owner_d = pick_win;
            rts_d   = 1'b0;
`ifdef ARB_BURST_LIMIT_EN
            if (at_limit || (pick_win != owner_q)) cnt_d = '0;
            else                                   cnt_d = cnt_q + CNT_W'(1);
`endif
         end
         GAP: begin
            rts_d = 1'b1;
         end
         default: begin
            owner_d = '0;
            rts_d   = 1'b0;
         end
      endcase
   end

   // Outputs: grant strobes only in a transfer cycle and never during reset.
   always_comb begin
      arb_if.grant    = owner_q & {NUM_PORTS{(state == XFER) && !rst}};
      arb_if.xbar_sel = owner_q;
      arb_if.rts      = rts_q;
   end

endmodule

// File: tb/tb_noc_rr_arbiter.sv
module tb_noc_rr_arbiter;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   noc_rr_arbiter_if #(.NUM_PORTS(5)) bus ();

   noc_rr_arbiter #(
      .NUM_PORTS(5),
      .MAX_BURST(4)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .arb_if(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [4:0] req;
      logic       dcts;
      logic       exp_rts;
      logic [4:0] exp_xbar;
      logic [4:0] exp_grant;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic [4:0] q, input logic d,
                               input logic er, input logic [4:0] ex, input logic [4:0] eg);
      vec_t v;
      v.rst = r; v.req = q; v.dcts = d;
      v.exp_rts = er; v.exp_xbar = ex; v.exp_grant = eg;
      return v;
   endfunction

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
      else n_pass++;
   endtask

   initial begin
      logic [4:0] exp_g;
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      bus.req  = 5'b11111;
      bus.dcts = 1'b1;

      // reset with all requests and dcts high
      vecs.push_back(mk(1, 5'b11111, 1, 0, 5'b00000, 5'b00000));
      vecs.push_back(mk(1, 5'b11111, 1, 0, 5'b00000, 5'b00000));
      // single requester, port 2
      vecs.push_back(mk(0, 5'b00100, 1, 0, 5'b00000, 5'b00000));
      vecs.push_back(mk(0, 5'b00100, 1, 1, 5'b00100, 5'b00100));
      vecs.push_back(mk(0, 5'b00100, 1, 0, 5'b00100, 5'b00000));
      vecs.push_back(mk(0, 5'b00100, 1, 1, 5'b00100, 5'b00100));
      vecs.push_back(mk(0, 5'b00100, 1, 0, 5'b00100, 5'b00000));
      vecs.push_back(mk(0, 5'b00000, 1, 1, 5'b00100, 5'b00100));
      vecs.push_back(mk(0, 5'b00000, 1, 0, 5'b00000, 5'b00000));
      // round-robin wrap: 3 -> 4 -> 1 -> 0
      vecs.push_back(mk(0, 5'b01000, 0, 0, 5'b00000, 5'b00000));
      vecs.push_back(mk(0, 5'b11010, 0, 1, 5'b01000, 5'b00000));
      vecs.push_back(mk(0, 5'b10010, 1, 1, 5'b01000, 5'b01000));
      vecs.push_back(mk(0, 5'b10010, 1, 0, 5'b10000, 5'b00000));
      vecs.push_back(mk(0, 5'b00010, 1, 1, 5'b10000, 5'b10000));
      vecs.push_back(mk(0, 5'b00010, 1, 0, 5'b00010, 5'b00000));
      vecs.push_back(mk(0, 5'b00001, 1, 1, 5'b00010, 5'b00010));
      // backpressure on port 0 with its request dropped
      vecs.push_back(mk(0, 5'b00001, 0, 0, 5'b00001, 5'b00000));
      for (int i = 0; i < 6; i++)
         vecs.push_back(mk(0, 5'b00000, 0, 1, 5'b00001, 5'b00000));
      vecs.push_back(mk(0, 5'b00000, 1, 1, 5'b00001, 5'b00001));
      vecs.push_back(mk(0, 5'b00000, 1, 0, 5'b00000, 5'b00000));
      vecs.push_back(mk(0, 5'b00000, 1, 0, 5'b00000, 5'b00000));
      // reset during WAIT with owner port 2
      vecs.push_back(mk(0, 5'b00100, 0, 0, 5'b00000, 5'b00000));
      vecs.push_back(mk(0, 5'b00100, 0, 1, 5'b00100, 5'b00000));
      vecs.push_back(mk(1, 5'b00100, 1, 1, 5'b00100, 5'b00000));
      vecs.push_back(mk(0, 5'b11111, 1, 0, 5'b00000, 5'b00000));
      vecs.push_back(mk(0, 5'b11111, 1, 1, 5'b00001, 5'b00001));
      vecs.push_back(mk(0, 5'b00000, 1, 0, 5'b00001, 5'b00000));
      vecs.push_back(mk(0, 5'b00000, 1, 1, 5'b00001, 5'b00001));
      vecs.push_back(mk(0, 5'b00000, 1, 0, 5'b00000, 5'b00000));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst      = vecs[i].rst;
         bus.req  = vecs[i].req;
         bus.dcts = vecs[i].dcts;
         #1;
         check($sformatf("vec%0d rts", i), {4'b0, bus.rts}, {4'b0, vecs[i].exp_rts});
         check($sformatf("vec%0d xbar_sel", i), bus.xbar_sel, vecs[i].exp_xbar);
         check($sformatf("vec%0d grant", i), bus.grant, vecs[i].exp_grant);
      end

      // burst sequence: ports 0 and 1 requesting continuously
      @(negedge clk);
      rst      = 1'b1;
      bus.req  = 5'b00000;
      bus.dcts = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      bus.req = 5'b00011;
      #1;
      check("burst idle rts", {4'b0, bus.rts}, 5'b00000);
      for (int g = 0; g < 16; g++) begin
`ifdef ARB_BURST_LIMIT_EN
         exp_g = ((g / 4) % 2 == 1) ? 5'b00010 : 5'b00001;
`else
         exp_g = 5'b00001;
`endif
         @(negedge clk);
         #1;
         check($sformatf("burst%0d grant", g), bus.grant, exp_g);
         check($sformatf("burst%0d xbar_sel", g), bus.xbar_sel, exp_g);
         @(negedge clk);
         #1;
         check($sformatf("burst%0d gap grant", g), bus.grant, 5'b00000);
         check($sformatf("burst%0d gap rts", g), {4'b0, bus.rts}, 5'b00000);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
